// File: rtl/mood_level_integrator.sv
// Mood level integrator: saturating up/down accumulator of stimulus pulses
// with a prescaled decay that pulls the level back toward midscale.
module mood_level_integrator #(
  parameter int unsigned N         = 7,
  parameter int unsigned INC_STEP  = 4,
  parameter int unsigned DEC_STEP  = 1,
  parameter int unsigned DECAY_DIV = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         stim_up,
  input  logic         stim_down,
  output logic [N-1:0] level,
  output logic         at_max,
  output logic         at_min,
  output logic         decay_tick
);

  localparam int unsigned PW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [N:0]    MID_W    = (N+1)'(2**(N-1));
  localparam logic [N:0]    MAX_W    = (N+1)'(2**N - 1);
  localparam logic [N:0]    INC_W    = (N+1)'(INC_STEP);
  localparam logic [N:0]    DEC_W    = (N+1)'(DEC_STEP);
  localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic [N-1:0]  level_d;
  logic          decay_due_c;
  logic [N:0]    lvl_x;
  logic [N:0]    sum_x;
  logic [N:0]    diff_x;

  // Next-state: prescaler wrap, then stimulus/decay update in priority order (N+1-bit math, clamped).
  always_comb begin
    pre_d       = pre_q;
    level_d     = level;
    decay_due_c = 1'b0;
    lvl_x       = {1'b0, level};
    sum_x       = '0;
    diff_x      = '0;
    if (ena) begin
      decay_due_c = (pre_q == PRE_LAST);
      pre_d       = decay_due_c ? '0 : pre_q + PW'(1);
      if (stim_up && stim_down) begin
        level_d = level;
      end else if (stim_up) begin
        sum_x   = lvl_x + INC_W;
        level_d = (sum_x > MAX_W) ? MAX_W[N-1:0] : sum_x[N-1:0];
      end else if (stim_down) begin
        level_d = (lvl_x < INC_W) ? '0 : N'(lvl_x - INC_W);
      end else if (decay_due_c) begin
        if (lvl_x > MID_W) begin
          diff_x  = lvl_x - MID_W;
          level_d = (diff_x > DEC_W) ? N'(lvl_x - DEC_W) : MID_W[N-1:0];
        end else if (lvl_x < MID_W) begin
          diff_x  = MID_W - lvl_x;
          level_d = (diff_x > DEC_W) ? N'(lvl_x + DEC_W) : MID_W[N-1:0];
        end
      end
    end
  end

  // State and registered flags; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= MID_W[N-1:0];
      pre_q      <= '0;
      decay_tick <= 1'b0;
      at_max     <= 1'b0;
      at_min     <= 1'b0;
    end else if (ena) begin
      level      <= level_d;
      pre_q      <= pre_d;
      decay_tick <= decay_due_c;
      at_max     <= (level_d == MAX_W[N-1:0]);
      at_min     <= (level_d == '0);
    end
  end

endmodule
